bias_relu_fire3_expand1: RTL and testbench
==========================================

Name: bias_relu_fire3_expand1

Overview:
- Consumes the 64-entry, 32-bit signed bias table of the fire3 expand1 layer, one entry per output channel.
- Sits between the expand1 MAC accumulator stream and the fire3 concat/writeback stage.
- Per accumulated output: adds the bias selected by an internal channel counter, requantizes by arithmetic right shift, applies ReLU, saturates to activation width.
- Tracks channel/pixel position and flags end of layer.

Parameters:
- NUM_CH, 64, output channels (bias table depth); channel counter wraps at NUM_CH-1.
- ACC_W, 32, accumulator and bias width, two's complement.
- OUT_W, 16, output activation width, two's complement.
- SHIFT, 8, arithmetic right shift applied after bias add.
- NUM_PIX, 3025, output pixels per layer (55x55).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- bias_mem  in  [ACC_W-1:0] x [0:NUM_CH-1]  bias table, static during operation.
- clr  in  1  synchronous restart: channel and pixel counters to 0, pipeline flushed.
- acc_data  in  ACC_W  signed accumulator for the current channel.
- acc_valid  in  1  acc_data valid.
- acc_ready  out  1  block accepts acc_data this cycle.
- out_data  out  OUT_W  biased, shifted, activated result.
- out_ch  out  6  channel index of out_data (clog2(NUM_CH)).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- pix_done  out  1  one-cycle pulse with the output beat of channel NUM_CH-1.
- layer_done  out  1  one-cycle pulse with the last beat of pixel NUM_PIX-1.

Behaviour:
- Reset (rst_n=0 at clk edge): out_data=0, out_ch=0, out_valid=0, pix_done=0, layer_done=0, all pipeline valids=0, ch_cnt=0, pix_cnt=0. acc_ready=0 during reset, 1 on the first cycle after.
- Pipeline has 2 stages, each with a valid bit.
  - advance = !s2_valid || out_ready.
  - acc_ready = advance (combinational; no input-to-output combinational data path).
- Input handshake: a beat transfers when acc_valid && acc_ready. There is no combinational path from acc_valid to acc_ready.
- Stage 1, on transfer:
  - s1_sum = sext(acc_data) + sext(bias_mem[ch_cnt]), ACC_W+1 bits, no overflow.
  - s1_ch = ch_cnt.
  - ch_cnt increments; it wraps to 0 after NUM_CH-1, and pix_cnt increments on that wrap.
  - pix_cnt wraps to 0 after NUM_PIX-1.
  - s1 captures last_ch and last_pix tags.
- Stage 2, on advance (takes s1 contents):
  - shifted = s1_sum >>> SHIFT, arithmetic, truncation toward -inf.
  - Activation as defined under Optional Feature.
  - Saturate to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Latency: 2 cycles from input transfer to out_valid when there is no backpressure. Throughput: 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_ch, pix_done and layer_done hold stable, and no stage advances.
- pix_done and layer_done are asserted alongside out_valid on the tagged beat. They stay asserted while that beat stalls and are cleared once the beat is accepted.
- clr: same effect as reset on the counters and valids. If clr and an input transfer occur in the same cycle, clr wins and the beat is dropped.
- bias_mem is read only at the stage-1 capture. Changing it mid-layer affects only later beats.

Optional Feature:
- Macro: FIRE3_BIAS_RELU_EN.
- Defined: values with shifted < 0 produce out_data = 0; saturation is effectively [0, 2^(OUT_W-1)-1].
- Undefined: no ReLU; signed saturation only (for layers whose activation is applied downstream).
- Latency and handshake are identical in both builds.

Test Plan:
- Bias 0 = 0xFFFFFEBF (-321). Reset, then acc=0x00001000 on ch0 -> out_data = (4096-321)>>>8 = 14, out_ch=0, out_valid 2 cycles after transfer.
- With RELU_EN: acc=-10000 on ch0 -> out_data=0. Without RELU_EN: out_data = (-10321)>>>8 = -41.
- acc=0x7FFFFFFF on ch3 (bias +1169) -> no wrap; out_data saturates to 32767.
- Stream 64 beats with out_ready=1 -> out_ch sequences 0..63, pix_done only on beat 63, and the next beat reports out_ch=0.
- Hold out_ready=0 for 5 cycles with acc_valid=1 -> acc_ready drops once stage 2 fills, out_data stays stable, no beats are lost or duplicated after release (compare against a scoreboard).
- Stream NUM_PIX*64 beats -> layer_done pulses exactly once, on the final beat. Then assert clr mid-stream -> next accepted beat reports out_ch=0 and pix_cnt restarts at 0.

Source files
------------

// File: rtl/bias_relu_fire3_expand1_if.sv
// Stream bundle for bias_relu_fire3_expand1: accumulator input and activation output.
// master drives accumulators and out_ready; slave is the bias/activation block.
interface bias_relu_fire3_expand1_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int CH_W  = 6
);
    logic [ACC_W-1:0] acc_data;
    logic             acc_valid;
    logic             acc_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             pix_done;
    logic             layer_done;

    modport master (
        output acc_data, acc_valid, out_ready,
        input  acc_ready, out_data, out_ch, out_valid, pix_done, layer_done
    );

    modport slave (
        input  acc_data, acc_valid, out_ready,
        output acc_ready, out_data, out_ch, out_valid, pix_done, layer_done
    );
endinterface

// File: rtl/bias_relu_fire3_expand1.sv
// fire3 expand1 bias add, requantize shift, saturate; ReLU when FIRE3_BIAS_RELU_EN.
// Two-stage pipeline tracking channel/pixel position and end-of-layer.
module bias_relu_fire3_expand1 #(
    parameter int NUM_CH  = 64,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 8,
    parameter int NUM_PIX = 3025
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] bias_mem [0:NUM_CH-1],
    input  logic             clr,
    bias_relu_fire3_expand1_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-(1 << (OUT_W-1)));

    logic                    advance;
    logic                    xfer;
    logic [CH_W-1:0]         ch_cnt;
    logic [PIX_W-1:0]        pix_cnt;
    logic [ACC_W-1:0]        bias;
    logic                    s1_valid;
    logic signed [ACC_W:0]   s1_sum;
    logic [CH_W-1:0]         s1_ch;
    logic                    s1_last_ch;
    logic                    s1_last_pix;
    logic                    s2_valid;
    logic signed [ACC_W:0]   shifted;
    logic [OUT_W-1:0]        act;

    assign advance       = !s2_valid || bus.out_ready;
    assign bus.acc_ready = rst_n && advance;
    assign xfer          = bus.acc_valid && bus.acc_ready;
    assign bus.out_valid = s2_valid;
    assign bias          = bias_mem[ch_cnt];

    always_comb begin
        shifted = s1_sum >>> SHIFT;
        act     = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            act = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            act = MIN_V[OUT_W-1:0];
        end
`ifdef FIRE3_BIAS_RELU_EN
        if (shifted[ACC_W]) begin
            act = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (xfer) begin
            if (ch_cnt == LAST_CH) begin
                ch_cnt  <= '0;
                pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    // clr shares the valid flush with reset; a beat captured alongside clr is dropped
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            bus.pix_done   <= 1'b0;
            bus.layer_done <= 1'b0;
        end else if (advance) begin
            s1_valid       <= xfer;
            s2_valid       <= s1_valid;
            bus.pix_done   <= s1_valid && s1_last_ch;
            bus.layer_done <= s1_valid && s1_last_ch && s1_last_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_sum      <= '0;
            s1_ch       <= '0;
            s1_last_ch  <= 1'b0;
            s1_last_pix <= 1'b0;
            bus.out_data <= '0;
            bus.out_ch   <= '0;
        end else begin
            if (xfer) begin
                s1_sum      <= $signed({bus.acc_data[ACC_W-1], bus.acc_data})
                             + $signed({bias[ACC_W-1], bias});
                s1_ch       <= ch_cnt;
                s1_last_ch  <= (ch_cnt == LAST_CH);
                s1_last_pix <= (pix_cnt == LAST_PIX);
            end
            if (advance && s1_valid) begin
                bus.out_data <= act;
                bus.out_ch   <= s1_ch;
            end
        end
    end
endmodule

// File: tb/tb_bias_relu_fire3_expand1.sv
// Bench for bias_relu_fire3_expand1: vector table plus scoreboard-checked streams.
// Small NUM_PIX keeps a full layer short; FIRE3_BIAS_RELU_EN selects expectations.
module tb_bias_relu_fire3_expand1;
    localparam int NPIX = 5;

    typedef struct {
        int data;
        int ch;
        bit pd;
        bit ld;
    } exp_t;

    typedef struct {
        logic [31:0] acc;
        int          ch;
        int          relu;
        int          lin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] bias_mem [0:63];

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t me;
    int   m_ch = 0;
    int   m_pix = 0;
    int   ld_cnt = 0;
    int   pd_cnt = 0;
    bit   stop = 1'b0;
    vec_t tbl [10];

    bias_relu_fire3_expand1_if #(.ACC_W(32), .OUT_W(16), .CH_W(6)) bus ();

    bias_relu_fire3_expand1 #(
        .NUM_CH(64), .ACC_W(32), .OUT_W(16), .SHIFT(8), .NUM_PIX(NPIX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bias_mem(bias_mem),
        .clr(clr),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int model(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        s = s >>> 8;
`ifdef FIRE3_BIAS_RELU_EN
        if (s < 0) return 0;
`endif
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    function automatic logic [31:0] rnd();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'(int'($urandom_range(0, 20000000)) - 10000000);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_exp(input int d, input int ch);
        exp_t e;
        e.data = d;
        e.ch   = ch;
        e.pd   = (m_ch == 63);
        e.ld   = e.pd && (m_pix == NPIX - 1);
        q.push_back(e);
        if (m_ch == 63) begin
            m_ch  = 0;
            m_pix = (m_pix == NPIX - 1) ? 0 : m_pix + 1;
        end else begin
            m_ch++;
        end
    endtask

    task automatic send(input logic [31:0] a, input int d, input int ch);
        int n;
        n = 0;
        @(negedge clk);
        bus.acc_valid = 1'b1;
        bus.acc_data  = a;
        #1;
        while (!bus.acc_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.acc_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got acc_ready 0 want 1");
        end else begin
            push_exp(d, ch);
            @(posedge clk);
        end
        #1;
        bus.acc_valid = 1'b0;
    endtask

    task automatic send_rnd();
        logic [31:0] a;
        a = rnd();
        send(a, model(a, bias_mem[m_ch]), m_ch);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid) begin
                if (bus.out_ready) begin
                    checks++;
                    if (bus.pix_done) pd_cnt++;
                    if (bus.layer_done) ld_cnt++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat got ch %0d data %0d want none",
                                 bus.out_ch, $signed(bus.out_data));
                    end else begin
                        me = q.pop_front();
                        if (int'($signed(bus.out_data)) != me.data ||
                            int'(bus.out_ch) != me.ch ||
                            bus.pix_done != me.pd || bus.layer_done != me.ld) begin
                            errors++;
                            $display("FAIL beat got d=%0d ch=%0d pd=%0b ld=%0b want d=%0d ch=%0d pd=%0b ld=%0b",
                                     $signed(bus.out_data), bus.out_ch, bus.pix_done,
                                     bus.layer_done, me.data, me.ch, me.pd, me.ld);
                        end
                    end
                end else if (q.size() != 0) begin
                    checks++;
                    if (int'($signed(bus.out_data)) != q[0].data ||
                        int'(bus.out_ch) != q[0].ch) begin
                        errors++;
                        $display("FAIL stall_hold got d=%0d ch=%0d want d=%0d ch=%0d",
                                 $signed(bus.out_data), bus.out_ch, q[0].data, q[0].ch);
                    end
                end
            end
        end
    end

    initial begin
        tbl[0] = '{32'd256000,     1,   998,    998};
        tbl[1] = '{32'(-70000),    2,     0,   -275};
        tbl[2] = '{32'h7FFFFFFF,   3, 32767,  32767};
        tbl[3] = '{32'h80000000,   4,     0, -32768};
        tbl[4] = '{32'd8388352,    5, 32767,  32767};
        tbl[5] = '{32'd8388508,    6, 32767,  32767};
        tbl[6] = '{32'(-8388808),  7,     0, -32768};
        tbl[7] = '{32'(-8388909),  8,     0, -32768};
        tbl[8] = '{32'(-656),      9,     0,     -1};
        tbl[9] = '{32'(-501),     10,     0,     -1};

        for (int i = 0; i < 64; i++) bias_mem[i] = 32'(i * 100 - 500);
        bias_mem[0] = 32'hFFFFFEBF;
        bias_mem[3] = 32'd1169;

        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acc_ready", int'(bus.acc_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_ch", int'(bus.out_ch), 0);
        chk("rst_pix_done", int'(bus.pix_done), 0);
        chk("rst_layer_done", int'(bus.layer_done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_acc_ready", int'(bus.acc_ready), 1);

        // first beat: ch0 bias -321, latency two cycles
        send(32'h00001000, 14, 0);
        @(negedge clk);
        chk("lat1_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat2_out_valid", int'(bus.out_valid), 1);
        chk("lat2_out_data", int'($signed(bus.out_data)), 14);

        for (int i = 0; i < 10; i++) begin
`ifdef FIRE3_BIAS_RELU_EN
            send(tbl[i].acc, tbl[i].relu, tbl[i].ch);
`else
            send(tbl[i].acc, tbl[i].lin, tbl[i].ch);
`endif
        end
        drain();

        // backpressure with a continuous input stream
        fork
            begin
                for (int i = 0; i < 20; i++) send_rnd();
            end
            begin
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("bp_acc_ready", int'(bus.acc_ready), 0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // clr with a simultaneous input transfer: the beat is dropped
        @(negedge clk);
        clr = 1'b1;
        bus.acc_valid = 1'b1;
        bus.acc_data  = 32'h00005555;
        #1;
        m_ch  = 0;
        m_pix = 0;
        @(negedge clk);
        clr = 1'b0;
        bus.acc_valid = 1'b0;
`ifdef FIRE3_BIAS_RELU_EN
        send(32'(-10000), 0, 0);
`else
        send(32'(-10000), -41, 0);
`endif
        drain();

        @(negedge clk);
        clr = 1'b1;
        m_ch  = 0;
        m_pix = 0;
        @(negedge clk);
        clr = 1'b0;

        // full layer with random downstream stalls
        ld_cnt = 0;
        pd_cnt = 0;
        stop   = 1'b0;
        fork
            begin
                for (int i = 0; i < NPIX * 64; i++) send_rnd();
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("layer_done_count", ld_cnt, 1);
        chk("pix_done_count", pd_cnt, NPIX);

        // clr mid-stream flushes in-flight beats
        for (int i = 0; i < 5; i++) send_rnd();
        @(negedge clk);
        bus.out_ready = 1'b0;
        clr = 1'b1;
        #3;
        q.delete();
        m_ch  = 0;
        m_pix = 0;
        @(negedge clk);
        clr = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_out_valid", int'(bus.out_valid), 0);

        ld_cnt = 0;
        pd_cnt = 0;
        for (int i = 0; i < 70; i++) send_rnd();
        drain();
        chk("restart_pix_done", pd_cnt, 1);
        chk("restart_layer_done", ld_cnt, 0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
